// File: rtl/mem_access_stage_pkg.sv
// Shared MEM-stage definitions: op codes, FSM states
// and small op classification helpers.
package mem_access_stage_pkg;

  localparam logic [3:0] MEM_NOP = 4'd0;
  localparam logic [3:0] MEM_LW  = 4'd1;
  localparam logic [3:0] MEM_LH  = 4'd2;
  localparam logic [3:0] MEM_LHU = 4'd3;
  localparam logic [3:0] MEM_LB  = 4'd4;
  localparam logic [3:0] MEM_LBU = 4'd5;
  localparam logic [3:0] MEM_SW  = 4'd6;
  localparam logic [3:0] MEM_SH  = 4'd7;
  localparam logic [3:0] MEM_SB  = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } mem_state_e;

  function automatic logic is_load(
    input logic [3:0] op
  );
    return (op >= MEM_LW) && (op <= MEM_LBU);
  endfunction

  function automatic logic is_store(
    input logic [3:0] op
  );
    return (op >= MEM_SW) && (op <= MEM_SB);
  endfunction

  // Byte ops are never misaligned.
  function automatic logic is_misaligned(
    input logic [3:0] op,
    input logic [1:0] a
  );
    logic word;
    logic half;
    word = (op == MEM_LW) || (op == MEM_SW);
    half = (op == MEM_LH) || (op == MEM_LHU)
        || (op == MEM_SH);
    return (word && (a != 2'b00)) || (half && a[0]);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store enables/replication and
// load slice extraction with sign/zero extension.
module mem_lane_align
  import mem_access_stage_pkg::*;
(
  input  logic [3:0]  st_op,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [3:0]  ld_op,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [31:0] b_sh;
  logic [31:0] h_sh;
  logic [7:0]  b;
  logic [15:0] h;

  // Store lanes; loads and SW use all four lanes.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    unique case (1'b1)
      (st_op == MEM_SH): begin
        st_be    = st_off[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      (st_op == MEM_SB): begin
        st_be    = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      default: ;
    endcase
  end

  // Load slice select and extension.
  always_comb begin
    b_sh    = rdata >> {ld_off, 3'b000};
    h_sh    = rdata >> {ld_off[1], 4'b0000};
    b       = b_sh[7:0];
    h       = h_sh[15:0];
    ld_data = '0;
    unique case (1'b1)
      (ld_op == MEM_LW):  ld_data = rdata;
      (ld_op == MEM_LH):  ld_data = {{16{h[15]}}, h};
      (ld_op == MEM_LHU): ld_data = {16'h0, h};
      (ld_op == MEM_LB):  ld_data = {{24{b[7]}}, b};
      (ld_op == MEM_LBU): ld_data = {24'h0, b};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: runs loads/stores on a req/ready bus,
// stalls upstream, and fills the MEM/WB register.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       ex_pc,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_rd2,
  input  logic [4:0]        ex_rf_rd,
  input  logic [1:0]        ex_memtoreg,
  input  logic              ex_regwrite,
  input  logic [3:0]        ex_memcontrol,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ready,
  output logic [31:0]       wb_pc,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [DATA_W-1:0] wb_mem_data,
  output logic [4:0]        wb_rf_rd,
  output logic [1:0]        wb_memtoreg,
  output logic              wb_regwrite,
  output logic              misalign_exc
);

  mem_state_e state, state_n;

  logic [1:0]        off_q;
  logic [3:0]        op_q;
  logic [DATA_W-1:0] ld_q;
  logic [3:0]        be_c;
  logic [DATA_W-1:0] wdata_c;
  logic [DATA_W-1:0] ld_c;
  logic              op_mis;
  logic              op_go;
  logic              bus_ld;
  logic              ld_en;
  logic              wb_en;
  logic              done;

  assign op_mis = is_misaligned(ex_memcontrol,
                                ex_alu_result[1:0]);
  assign op_go  = (is_load(ex_memcontrol)
                | is_store(ex_memcontrol)) & ~op_mis;
  assign done   = (state == S_DONE);

  mem_lane_align u_align (
    .st_op    (ex_memcontrol),
    .st_off   (ex_alu_result[1:0]),
    .st_data  (ex_rd2),
    .st_be    (be_c),
    .st_wdata (wdata_c),
    .ld_op    (op_q),
    .ld_off   (off_q),
    .rdata    (dmem_rdata),
    .ld_data  (ld_c)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (op_go) state_n = S_BUSY;
      S_BUSY:  if (dmem_ready) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Stall/exception and register enables; reset
  // forces stall low even with a held memory op.
  always_comb begin
    stall        = 1'b0;
    misalign_exc = 1'b0;
    bus_ld       = 1'b0;
    ld_en        = 1'b0;
    wb_en        = 1'b0;
    unique case (state)
      S_IDLE: begin
        stall        = op_go;
        misalign_exc = op_mis;
        bus_ld       = op_go;
        wb_en        = ~op_go;
      end
      S_BUSY: begin
        stall = 1'b1;
        ld_en = dmem_ready;
      end
      S_DONE:  wb_en = 1'b1;
      default: ;
    endcase
    if (rst) begin
      stall        = 1'b0;
      misalign_exc = 1'b0;
    end
  end

  // Bus request and the fields held through BUSY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      off_q      <= '0;
      op_q       <= MEM_NOP;
    end else if (bus_ld) begin
      dmem_req   <= 1'b1;
      dmem_we    <= is_store(ex_memcontrol);
      dmem_addr  <= {ex_alu_result[ADDR_W-1:2], 2'b00};
      dmem_be    <= be_c;
      dmem_wdata <= wdata_c;
      off_q      <= ex_alu_result[1:0];
      op_q       <= ex_memcontrol;
    end else if (ld_en) begin
      dmem_req   <= 1'b0;
    end
  end

  // Formatted load data; stores yield zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        ld_q <= '0;
    else if (ld_en) ld_q <= ld_c;
  end

  // MEM/WB register; misaligned ops become bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_pc         <= '0;
      wb_alu_result <= '0;
      wb_mem_data   <= '0;
      wb_rf_rd      <= '0;
      wb_memtoreg   <= 2'b00;
      wb_regwrite   <= 1'b0;
    end else if (wb_en) begin
      wb_pc         <= ex_pc;
      wb_alu_result <= ex_alu_result;
      wb_mem_data   <= done ? ld_q : '0;
      wb_rf_rd      <= ex_rf_rd;
      wb_memtoreg   <= ex_memtoreg;
      wb_regwrite   <= ex_regwrite & ~op_mis;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: drives
// EX/MEM ops, acts as bus slave, checks MEM/WB.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ex_pc = '0;
  logic [31:0] ex_alu_result = '0;
  logic [31:0] ex_rd2 = '0;
  logic [4:0]  ex_rf_rd = '0;
  logic [1:0]  ex_memtoreg = '0;
  logic        ex_regwrite = 1'b0;
  logic [3:0]  ex_memcontrol = '0;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_ready = 1'b0;
  logic [31:0] wb_pc;
  logic [31:0] wb_alu_result;
  logic [31:0] wb_mem_data;
  logic [4:0]  wb_rf_rd;
  logic [1:0]  wb_memtoreg;
  logic        wb_regwrite;
  logic        misalign_exc;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [4:0]  rd;
    logic [1:0]  m2r;
    logic        rw;
  } wb_t;

  wb_t sbq[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  seq = 0;

  mem_access_stage dut (
    .clk           (clk),
    .rst           (rst),
    .ex_pc         (ex_pc),
    .ex_alu_result (ex_alu_result),
    .ex_rd2        (ex_rd2),
    .ex_rf_rd      (ex_rf_rd),
    .ex_memtoreg   (ex_memtoreg),
    .ex_regwrite   (ex_regwrite),
    .ex_memcontrol (ex_memcontrol),
    .stall         (stall),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_be       (dmem_be),
    .dmem_wdata    (dmem_wdata),
    .dmem_rdata    (dmem_rdata),
    .dmem_ready    (dmem_ready),
    .wb_pc         (wb_pc),
    .wb_alu_result (wb_alu_result),
    .wb_mem_data   (wb_mem_data),
    .wb_rf_rd      (wb_rf_rd),
    .wb_memtoreg   (wb_memtoreg),
    .wb_regwrite   (wb_regwrite),
    .misalign_exc  (misalign_exc)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  // Drive one op, serve the bus, then pop and
  // compare the MEM/WB entry it produces.
  task automatic issue(
    input logic [3:0]  op,
    input logic [31:0] addr,
    input logic [31:0] rd2,
    input int          waits,
    input logic [31:0] rdata,
    input logic [3:0]  e_be,
    input logic [31:0] e_wd,
    input logic [31:0] e_mem,
    input logic        e_mis,
    input int          e_stall
  );
    wb_t e;
    wb_t g;
    int  sc;
    int  cyc;
    int  w;
    bit  bus_ok;
    @(negedge clk);
    seq++;
    ex_pc         = 32'h1000 + 32'(seq * 4);
    ex_alu_result = addr;
    ex_rd2        = rd2;
    ex_rf_rd      = 5'(seq + 3);
    ex_memtoreg   = 2'(seq);
    ex_regwrite   = 1'b1;
    ex_memcontrol = op;
    e.pc  = ex_pc;
    e.alu = addr;
    e.mem = e_mem;
    e.rd  = ex_rf_rd;
    e.m2r = ex_memtoreg;
    e.rw  = ~e_mis;
    sbq.push_back(e);
    #1;
    sc = 0;
    cyc = 0;
    w = 0;
    bus_ok = 0;
    while (stall && cyc < 40) begin
      sc++;
      if (dmem_req) begin
        if (!bus_ok) begin
          chk("addr", dmem_addr, addr & ~32'h3);
          chk("be", 32'(dmem_be), 32'(e_be));
          chk("wdata", dmem_wdata, e_wd);
          chk("we", 32'(dmem_we),
              32'(is_store(op)));
          bus_ok = 1;
        end
        dmem_ready = (w == waits);
        dmem_rdata = rdata;
        w++;
      end
      @(negedge clk);
      dmem_ready = 1'b0;
      #1;
      cyc++;
    end
    if (cyc >= 40) chk("timeout", 1, 0);
    chk("stall_cyc", 32'(sc), 32'(e_stall));
    chk("misalign", 32'(misalign_exc), 32'(e_mis));
    if (e_mis) chk("req_idle", 32'(dmem_req), 0);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      g = sbq.pop_front();
      chk("wb_pc", wb_pc, g.pc);
      chk("wb_alu", wb_alu_result, g.alu);
      chk("wb_mem", wb_mem_data, g.mem);
      chk("wb_rd", 32'(wb_rf_rd), 32'(g.rd));
      chk("wb_m2r", 32'(wb_memtoreg), 32'(g.m2r));
      chk("wb_rw", 32'(wb_regwrite), 32'(g.rw));
    end
  endtask

  initial begin
    #3;
    chk("rst_req", 32'(dmem_req), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wb_pc", wb_pc, 0);
    chk("rst_wb_rw", 32'(wb_regwrite), 0);
    chk("rst_wb_m2r", 32'(wb_memtoreg), 0);
    chk("rst_exc", 32'(misalign_exc), 0);
    @(negedge clk);
    rst = 1'b0;

    // op, addr, rd2, waits, rdata, be, wdata, mem, mis, stall
    issue(MEM_NOP, 32'h1234, 0, 0, 0,
          4'h0, 0, 0, 0, 0);
    issue(MEM_SB, 32'h103, 32'hAABBCCDD, 0, 0,
          4'b1000, 32'hDDDDDDDD, 0, 0, 2);
    issue(MEM_LB, 32'h202, 0, 2, 32'h00F00000,
          4'b1111, 0, 32'hFFFFFFF0, 0, 4);
    issue(MEM_LBU, 32'h202, 0, 2, 32'h00F00000,
          4'b1111, 0, 32'h000000F0, 0, 4);
    issue(MEM_LH, 32'h06, 0, 0, 32'h80010000,
          4'b1111, 0, 32'hFFFF8001, 0, 2);
    issue(MEM_LHU, 32'h06, 0, 1, 32'h80010000,
          4'b1111, 0, 32'h00008001, 0, 3);
    issue(MEM_LW, 32'h01, 0, 0, 0,
          4'h0, 0, 0, 1, 0);
    issue(MEM_SH, 32'h0A, 32'h1234ABCD, 1, 0,
          4'b1100, 32'hABCDABCD, 0, 0, 3);
    issue(MEM_SH, 32'h0C, 32'h1234ABCD, 0, 0,
          4'b0011, 32'hABCDABCD, 0, 0, 2);
    issue(MEM_SW, 32'h10, 32'hCAFEF00D, 1, 0,
          4'b1111, 32'hCAFEF00D, 0, 0, 3);
    issue(MEM_LW, 32'h20, 0, 0, 32'h11223344,
          4'b1111, 0, 32'h11223344, 0, 2);
    issue(MEM_LB, 32'h21, 0, 0, 32'h11228344,
          4'b1111, 0, 32'hFFFFFF83, 0, 2);
    issue(4'd15, 32'h30, 0, 0, 0,
          4'h0, 0, 0, 0, 0);
    issue(MEM_SH, 32'h03, 32'h5555, 0, 0,
          4'h0, 0, 0, 1, 0);

    // Abort an access with reset while BUSY.
    @(negedge clk);
    ex_memcontrol = MEM_LW;
    ex_alu_result = 32'h80;
    dmem_ready    = 1'b0;
    @(negedge clk);
    #1;
    chk("busy_req", 32'(dmem_req), 1);
    chk("busy_stall", 32'(stall), 1);
    rst = 1'b1;
    #1;
    chk("arst_req", 32'(dmem_req), 0);
    chk("arst_stall", 32'(stall), 0);
    ex_memcontrol = MEM_NOP;
    @(negedge clk);
    rst = 1'b0;

    issue(MEM_LW, 32'h40, 0, 1, 32'hDEADBEEF,
          4'b1111, 0, 32'hDEADBEEF, 0, 3);

    @(negedge clk);
    ex_memcontrol = MEM_NOP;
    chk("sb_drain", 32'(sbq.size()), 0);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
